ad9958_sweep_sequencer: RTL and testbench

Per-channel linear frequency sweep scheduler for the AD9958 two-channel DDS controller core. It drives the core's `ftw_ch0`/`ftw_ch1`/`asf_ch0`/`asf_ch1` inputs and paces itself on the core's `io_update` pulse, so exactly one sweep point is committed per configurable number of DDS update cycles. In IDLE it passes manual tuning words straight through, so the core behaves as a static synthesizer.

---
 rtl/ad9958_sweep_sequencer_pkg.sv | 14 +
 rtl/ad9958_ftw_accum.sv | 48 ++++
 rtl/ad9958_sweep_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_ad9958_sweep_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ad9958_sweep_sequencer_pkg.sv
// Shared constants and FSM encoding for the AD9958 sweep sequencer.
package ad9958_sweep_sequencer_pkg;

  localparam int FTW_W_DEF = 32;
  localparam int ASF_W_DEF = 10;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } seq_state_t;

endpackage

// File: rtl/ad9958_ftw_accum.sv
// Registered frequency tuning word with parallel load and a wrapping
// (mod 2^FTW_W) add/subtract step.
module ad9958_ftw_accum
  import ad9958_sweep_sequencer_pkg::*;
#(
  parameter int FTW_W = FTW_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [FTW_W-1:0] load_value,
  input  logic             step_en,
  input  logic [FTW_W-1:0] step,
  input  logic             dir_down,
  output logic [FTW_W-1:0] ftw
);

  logic [FTW_W-1:0] ftw_r;
  logic [FTW_W-1:0] ftw_next_s;

  // Next tuning word: load has priority over stepping.
  always_comb begin
    ftw_next_s = ftw_r;
    if (load) begin
      ftw_next_s = load_value;
    end else if (step_en) begin
      if (dir_down) begin
        ftw_next_s = ftw_r - step;
      end else begin
        ftw_next_s = ftw_r + step;
      end
    end else begin
      ftw_next_s = ftw_r;
    end
  end

  // Tuning word register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ftw_r <= {FTW_W{1'b0}};
    end else begin
      ftw_r <= ftw_next_s;
    end
  end

  assign ftw = ftw_r;

endmodule

// File: rtl/ad9958_sweep_sequencer.sv
// Linear per-channel frequency sweep paced by the DDS core's io_update pulse;
// passes manual tuning words through while idle.
module ad9958_sweep_sequencer
  import ad9958_sweep_sequencer_pkg::*;
#(
  parameter int FTW_W = FTW_W_DEF,
  parameter int ASF_W = ASF_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [FTW_W-1:0] ftw_start_ch0,
  input  logic [FTW_W-1:0] ftw_start_ch1,
  input  logic [FTW_W-1:0] ftw_step_ch0,
  input  logic [FTW_W-1:0] ftw_step_ch1,
  input  logic [1:0]       dir_down,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [CNT_W-1:0] dwell,
  input  logic [ASF_W-1:0] asf_ch0_in,
  input  logic [ASF_W-1:0] asf_ch1_in,
  input  logic             io_update,
  output logic [FTW_W-1:0] ftw_ch0,
  output logic [FTW_W-1:0] ftw_ch1,
  output logic [ASF_W-1:0] asf_ch0,
  output logic [ASF_W-1:0] asf_ch1,
  output logic             sweeping,
  output logic             done,
  output logic [CNT_W-1:0] step_index
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_t       state_r, state_next_s;
  logic             io_update_q_r;
  logic             edge_s;
  logic [CNT_W-1:0] dwell_r, dwell_cnt_r, num_steps_r, step_index_r;
  logic [FTW_W-1:0] step_ch0_r, step_ch1_r;
  logic [1:0]       dir_r;
  logic [ASF_W-1:0] asf_ch0_r, asf_ch1_r;
  logic             done_r, sweeping_r;
  logic             last_dwell_s, last_point_s;
  logic             load_s, capture_s, step_en_s, done_s, dwell_clear_s, dwell_inc_s;

  assign edge_s       = io_update & ~io_update_q_r;
  assign last_dwell_s = (dwell_cnt_r == (dwell_r - CNT_ONE));
  assign last_point_s = (step_index_r == num_steps_r);

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; abort overrides everything.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (start) begin
          state_next_s = ST_ARMED;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (edge_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_ARMED;
        end
      end
      ST_RUN: begin
        if (abort || (edge_s && last_dwell_s && last_point_s)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output decode: datapath strobes per state.
  always_comb begin
    load_s        = 1'b0;
    capture_s     = 1'b0;
    step_en_s     = 1'b0;
    done_s        = 1'b0;
    dwell_clear_s = 1'b0;
    dwell_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s    = 1'b1;
        capture_s = start & ~abort;
      end
      ST_ARMED: begin
        dwell_clear_s = edge_s & ~abort;
      end
      ST_RUN: begin
        if (edge_s && !abort) begin
          if (last_dwell_s) begin
            dwell_clear_s = 1'b1;
            done_s        = last_point_s;
            step_en_s     = ~last_point_s;
          end else begin
            dwell_inc_s = 1'b1;
          end
        end else begin
          dwell_inc_s = 1'b0;
        end
      end
      default: load_s = 1'b1;
    endcase
  end

  // Sweep parameters, counters, amplitude words and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_update_q_r <= 1'b0;
      dwell_r       <= CNT_ONE;
      num_steps_r   <= CNT_ZERO;
      step_ch0_r    <= {FTW_W{1'b0}};
      step_ch1_r    <= {FTW_W{1'b0}};
      dir_r         <= 2'b00;
      dwell_cnt_r   <= CNT_ZERO;
      step_index_r  <= CNT_ZERO;
      asf_ch0_r     <= {ASF_W{1'b0}};
      asf_ch1_r     <= {ASF_W{1'b0}};
      done_r        <= 1'b0;
      sweeping_r    <= 1'b0;
    end else begin
      io_update_q_r <= io_update;
      if (capture_s) begin
        dwell_r     <= (dwell == CNT_ZERO) ? CNT_ONE : dwell;
        num_steps_r <= num_steps;
        step_ch0_r  <= ftw_step_ch0;
        step_ch1_r  <= ftw_step_ch1;
        dir_r       <= dir_down;
      end
      if (dwell_clear_s) begin
        dwell_cnt_r <= CNT_ZERO;
      end else if (dwell_inc_s) begin
        dwell_cnt_r <= dwell_cnt_r + CNT_ONE;
      end
      if (load_s) begin
        step_index_r <= CNT_ZERO;
        asf_ch0_r    <= asf_ch0_in;
        asf_ch1_r    <= asf_ch1_in;
      end else if (step_en_s) begin
        step_index_r <= step_index_r + CNT_ONE;
      end
      done_r     <= done_s;
      sweeping_r <= (state_next_s != ST_IDLE);
    end
  end

  ad9958_ftw_accum #(.FTW_W(FTW_W)) u_accum_ch0 (
    .clock      (clock),
    .reset      (reset),
    .load       (load_s),
    .load_value (ftw_start_ch0),
    .step_en    (step_en_s),
    .step       (step_ch0_r),
    .dir_down   (dir_r[0]),
    .ftw        (ftw_ch0)
  );

  ad9958_ftw_accum #(.FTW_W(FTW_W)) u_accum_ch1 (
    .clock      (clock),
    .reset      (reset),
    .load       (load_s),
    .load_value (ftw_start_ch1),
    .step_en    (step_en_s),
    .step       (step_ch1_r),
    .dir_down   (dir_r[1]),
    .ftw        (ftw_ch1)
  );

  assign asf_ch0    = asf_ch0_r;
  assign asf_ch1    = asf_ch1_r;
  assign done       = done_r;
  assign sweeping   = sweeping_r;
  assign step_index = step_index_r;

endmodule

// File: tb/tb_ad9958_sweep_sequencer.sv
// Directed bench for the sweep sequencer: expected sweep points are queued
// when each io_update pulse is driven and compared once the DUT reacts.
module tb_ad9958_sweep_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] ftw_start_ch0 = 32'hAAAA_5555;
  logic [31:0] ftw_start_ch1 = 32'h1234_5678;
  logic [31:0] ftw_step_ch0  = 32'h0;
  logic [31:0] ftw_step_ch1  = 32'h0;
  logic [1:0]  dir_down      = 2'b00;
  logic [15:0] num_steps     = 16'd0;
  logic [15:0] dwell         = 16'd1;
  logic [9:0]  asf_ch0_in    = 10'h155;
  logic [9:0]  asf_ch1_in    = 10'h2AA;
  logic        io_update     = 1'b0;
  logic [31:0] ftw_ch0, ftw_ch1;
  logic [9:0]  asf_ch0, asf_ch1;
  logic        sweeping, done;
  logic [15:0] step_index;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_ftw_q[$];
  logic        exp_done_q[$];
  logic [15:0] exp_idx_q[$];

  ad9958_sweep_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .ftw_start_ch0(ftw_start_ch0), .ftw_start_ch1(ftw_start_ch1),
    .ftw_step_ch0(ftw_step_ch0), .ftw_step_ch1(ftw_step_ch1),
    .dir_down(dir_down), .num_steps(num_steps), .dwell(dwell),
    .asf_ch0_in(asf_ch0_in), .asf_ch1_in(asf_ch1_in), .io_update(io_update),
    .ftw_ch0(ftw_ch0), .ftw_ch1(ftw_ch1), .asf_ch0(asf_ch0), .asf_ch1(asf_ch1),
    .sweeping(sweeping), .done(done), .step_index(step_index)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  // One io_update pulse from the core, then the queued point is checked.
  task automatic upd(input string tag, input logic ch, input logic [31:0] ftw_exp,
                     input logic done_exp, input logic [15:0] idx_exp);
    exp_ftw_q.push_back(ftw_exp);
    exp_done_q.push_back(done_exp);
    exp_idx_q.push_back(idx_exp);
    @(posedge clock); #1 io_update = 1'b1;
    @(posedge clock); #1 io_update = 1'b0;
    chk({tag, "_ftw"}, ch ? ftw_ch1 : ftw_ch0, exp_ftw_q.pop_front());
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done_q.pop_front()});
    chk({tag, "_idx"}, {16'd0, step_index}, {16'd0, exp_idx_q.pop_front()});
    repeat (6) @(posedge clock);
  endtask

  initial begin
    // Reset state, with non-zero manual inputs present.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ftw0", ftw_ch0, 32'h0);
    chk("rst_ftw1", ftw_ch1, 32'h0);
    chk("rst_asf0", {22'd0, asf_ch0}, 32'h0);
    chk("rst_flags", {30'd0, sweeping, done}, 32'h0);
    chk("rst_idx", {16'd0, step_index}, 32'h0);
    reset = 1'b0;

    // Idle passthrough.
    ftw_start_ch0 = 32'h1000_0000;
    asf_ch0_in    = 10'h3FF;
    @(posedge clock); #1;
    chk("idle_ftw0", ftw_ch0, 32'h1000_0000);
    chk("idle_asf0", {22'd0, asf_ch0}, 32'h0000_03FF);

    // Basic up-sweep on ch0, ch1 stepping alongside.
    ftw_start_ch0 = 32'h100; ftw_step_ch0 = 32'h10;
    ftw_start_ch1 = 32'h500; ftw_step_ch1 = 32'h1;
    dir_down = 2'b00; num_steps = 16'd3; dwell = 16'd1;
    do_start();
    chk("up_armed", {31'd0, sweeping}, 32'h1);
    ftw_start_ch0 = 32'hDEAD; asf_ch0_in = 10'h001; ftw_step_ch0 = 32'h7;
    @(posedge clock); #1;
    chk("up_hold_ftw", ftw_ch0, 32'h100);
    chk("up_asf_frozen", {22'd0, asf_ch0}, 32'h3FF);
    upd("up_e1", 1'b0, 32'h100, 1'b0, 16'd0);
    upd("up_e2", 1'b0, 32'h110, 1'b0, 16'd1);
    do_start();
    upd("up_e3", 1'b0, 32'h120, 1'b0, 16'd2);
    upd("up_e4", 1'b0, 32'h130, 1'b0, 16'd3);
    chk("up_ch1", ftw_ch1, 32'h503);
    upd("up_e5", 1'b0, 32'h130, 1'b1, 16'd3);
    chk("up_post_ftw", ftw_ch0, 32'hDEAD);
    chk("up_post_flags", {30'd0, sweeping, done}, 32'h0);
    chk("up_post_asf", {22'd0, asf_ch0}, 32'h001);

    // Down-wrap with dwell on ch1.
    ftw_start_ch1 = 32'h8; ftw_step_ch1 = 32'h10;
    dir_down = 2'b10; num_steps = 16'd1; dwell = 16'd2;
    do_start();
    upd("dn_e1", 1'b1, 32'h8, 1'b0, 16'd0);
    upd("dn_e2", 1'b1, 32'h8, 1'b0, 16'd0);
    upd("dn_e3", 1'b1, 32'hFFFF_FFF8, 1'b0, 16'd1);
    upd("dn_e4", 1'b1, 32'hFFFF_FFF8, 1'b0, 16'd1);
    upd("dn_e5", 1'b1, 32'hFFFF_FFF8, 1'b1, 16'd1);

    // dwell 0 behaves as 1; a single-point sweep.
    ftw_start_ch0 = 32'h4444; ftw_step_ch0 = 32'h1;
    dir_down = 2'b00; num_steps = 16'd0; dwell = 16'd0;
    do_start();
    upd("z_e1", 1'b0, 32'h4444, 1'b0, 16'd0);
    upd("z_e2", 1'b0, 32'h4444, 1'b1, 16'd0);

    // Abort mid-RUN.
    ftw_start_ch0 = 32'h100; ftw_step_ch0 = 32'h10;
    num_steps = 16'd3; dwell = 16'd1;
    do_start();
    ftw_start_ch0 = 32'h777;
    upd("ab_e1", 1'b0, 32'h100, 1'b0, 16'd0);
    upd("ab_e2", 1'b0, 32'h110, 1'b0, 16'd1);
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    chk("ab_flags", {30'd0, sweeping, done}, 32'h0);
    @(posedge clock); #1;
    chk("ab_pass", ftw_ch0, 32'h777);
    upd("ab_idle", 1'b0, 32'h777, 1'b0, 16'd0);

    // start and abort together: stays idle.
    @(posedge clock); #1 start = 1'b1; abort = 1'b1;
    @(posedge clock); #1 start = 1'b0; abort = 1'b0;
    chk("sa_sweep", {31'd0, sweeping}, 32'h0);
    upd("sa_idle", 1'b0, 32'h777, 1'b0, 16'd0);

    // Asynchronous reset mid-sweep, then a fresh sweep.
    ftw_start_ch0 = 32'h100;
    do_start();
    upd("rs_e1", 1'b0, 32'h100, 1'b0, 16'd0);
    upd("rs_e2", 1'b0, 32'h110, 1'b0, 16'd1);
    @(posedge clock); #3 reset = 1'b1;
    #1;
    chk("rs_ftw0", ftw_ch0, 32'h0);
    chk("rs_flags", {30'd0, sweeping, done}, 32'h0);
    chk("rs_idx", {16'd0, step_index}, 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    do_start();
    upd("rs2_e1", 1'b0, 32'h100, 1'b0, 16'd0);
    upd("rs2_e2", 1'b0, 32'h110, 1'b0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
